// File: rtl/fifo_reader.sv
// fifo_reader: read-side master for an 8-deep FIFO whose RAM has a registered
// read port. Issues one read per cycle while the FIFO is non-empty and
// downstream credit exists, and absorbs the one-cycle RAM latency in a
// 2-entry output buffer.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            enables issuing new FIFO reads
//   fifo_empty    FIFO empty flag (sampled combinationally)
//   fifo_rdata    FIFO read data, valid the cycle after fifo_rd
//   fifo_rd       FIFO read strobe (combinational)
//   out_data      head word of the output buffer (registered)
//   out_valid     out_data holds a valid word (registered)
//   out_ready     consumer accepts the head word this cycle
//   rd_count      wrapping count of words accepted by the consumer
module fifo_reader #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_rdata,
  output logic             fifo_rd,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] rd_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               inflight_q;
  logic [DW-1:0]      head_q, head_d;
  logic [DW-1:0]      tail_q, tail_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pop_c;
  logic               cap_c;
  logic [2:0]         credit_c;
  logic               rd_c;

  // Handshake and capture strobes; capture is unconditional one cycle after a read.
  assign pop_c = out_valid_q & out_ready;
  assign cap_c = inflight_q;

  // Slots committed after this edge; a read is allowed only if it still fits.
  // pop implies occupancy >= 1, so the subtraction cannot underflow.
  assign credit_c = {1'b0, state_q} + 3'(inflight_q) - 3'(pop_c);
  assign rd_c     = rst_n & en & ~fifo_empty & (credit_c < 3'd2);

  // Buffer occupancy / ordering next-state logic.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q + CNT_W'(pop_c);
    out_valid_d = out_valid_q;
    case (state_q)
      EMPTY: begin
        if (cap_c) begin
          head_d  = fifo_rdata;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({cap_c, pop_c})
          2'b11: head_d = fifo_rdata;
          2'b10: begin
            tail_d  = fifo_rdata;
            state_d = FULL;
          end
          2'b01: state_d = EMPTY;
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        // Credit prevents capture here; the pop+capture arm keeps order regardless.
        if (pop_c) begin
          head_d = tail_q;
          if (cap_c) begin
            tail_d = fifo_rdata;
          end else begin
            state_d = ONE;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= rd_c;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fifo_rd   = rd_c;
  assign out_data  = head_q;
  assign out_valid = out_valid_q;
  assign rd_count  = cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: drives fifo_reader from a behavioural 8-deep FIFO with a
// registered read port. Words written to the FIFO are pushed to a scoreboard
// queue and popped/compared whenever the consumer accepts a word.
module tb_fifo_reader;
  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_rdata = '0;
  logic             fifo_rd;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] rd_count;

  always #5 clk = ~clk;

  fifo_reader #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rd_count   (rd_count)
  );

  // FIFO model: pointers survive a reader reset, read data is registered.
  logic [DW-1:0] mem [8];
  logic [3:0]    wptr = '0;
  logic [3:0]    rptr = '0;
  assign fifo_empty = (wptr == rptr);
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_rdata <= mem[rptr[2:0]];
      rptr       <= rptr + 4'd1;
    end
  end

  logic [DW-1:0]    exp_q[$];
  int               checks = 0;
  int               fails  = 0;
  int               cyc = 0;
  int               reads = 0;
  int               pops = 0;
  int               first_rd = -1;
  int               last_rd = -1;
  int               first_vld = -1;
  int               epoch = 0;
  int               seen_epoch = 0;
  logic             stall_q = 1'b0;
  logic [DW-1:0]    stall_data = '0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Monitor: outputs and inputs both stable at the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (stall_q && seen_epoch == epoch) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(stall_data));
      end
      seen_epoch = epoch;
      if (fifo_rd) begin
        chk("rd_when_empty", 32'(fifo_empty), 32'd0);
        reads++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        pops++;
        exp_cnt = exp_cnt + 8'd1;
        if (exp_q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
        else chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wptr[2:0]] = v;
    wptr = wptr + 4'd1;
    exp_q.push_back(v);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick(2);
  endtask

  // Short reset pulse; words already read from the FIFO are lost.
  task automatic rst_pulse();
    int n;
    rst_n = 1'b0;
    epoch++;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_cnt", 32'(rd_count), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    #2;
    rst_n = 1'b1;
    n = reads - pops;
    repeat (n) void'(exp_q.pop_front());
    reads   = pops;
    exp_cnt = '0;
  endtask

  initial begin
    int r0;
    int p0;
    int guard;
    rst_n     = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_cnt", 32'(rd_count), 32'd0);
    chk("reset_rd", 32'(fifo_rd), 32'd0);

    // 1: preloaded 1..5, streaming
    for (int i = 1; i <= 5; i++) push(8'(i));
    tick();
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    drain(50);
    chk("t1_reads", 32'(reads), 32'd5);
    chk("t1_burst", 32'(last_rd - first_rd), 32'd4);
    chk("t1_latency", 32'(first_vld - first_rd), 32'd2);
    chk("t1_cnt", 32'(rd_count), 32'd5);
    chk("t1_rd_idle", 32'(fifo_rd), 32'd0);

    // 2: consumer stalled, only two reads may issue
    out_ready = 1'b0;
    r0 = reads;
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(10);
    chk("t2_reads", 32'(reads - r0), 32'd2);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_head", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    drain(60);
    chk("t2_cnt", 32'(rd_count), 32'd13);

    // 3: toggling ready
    r0 = reads;
    for (int i = 10; i <= 13; i++) push(8'(i));
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    drain(20);
    chk("t3_reads", 32'(reads - r0), 32'd4);
    chk("t3_cnt", 32'(rd_count), 32'd17);

    // 4: en high for one cycle only
    en = 1'b0;
    push(8'd20); push(8'd21); push(8'd22);
    tick(2);
    r0 = reads;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick(10);
    chk("t4_reads", 32'(reads - r0), 32'd1);
    chk("t4_left", 32'(exp_q.size()), 32'd2);
    chk("t4_cnt", 32'(rd_count), 32'd18);
    en = 1'b1;
    drain(30);
    chk("t4_reads_all", 32'(reads - r0), 32'd3);
    chk("t4_cnt_all", 32'(rd_count), 32'd20);

    // 5: reset while buffer full
    out_ready = 1'b0;
    for (int i = 30; i <= 37; i++) push(8'(i));
    tick(8);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_head", 32'(out_data), 32'd30);
    chk("t5_inbuf", 32'(reads - pops), 32'd2);
    rst_pulse();
    chk("t5_left", 32'(exp_q.size()), 32'd6);
    out_ready = 1'b1;
    drain(40);
    chk("t5_cnt", 32'(rd_count), 32'd6);

    // 6: 256-word stream wraps the counter
    rst_pulse();
    p0 = pops;
    guard = 0;
    for (int k = 0; k < 256; k++) begin
      while (4'(wptr - rptr) >= 4'd8 && guard < 2000) begin
        tick();
        guard++;
      end
      push(8'(k));
      tick();
    end
    chk("t6_guard", 32'(guard < 2000), 32'd1);
    drain(60);
    chk("t6_pops", 32'(pops - p0), 32'd256);
    chk("t6_cnt_wrap", 32'(rd_count), 32'd0);
    chk("t6_cnt_model", 32'(rd_count), 32'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule
